// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bit counter width, never below one bit (WIDTH=1 still needs a flop).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_structural.sv
// Gate-level full adder built from two half adders.
module full_adder_structural (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic s0;
    logic c0;
    logic c1;

    half_adder_structural u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder_structural u_ha1 (
        .a     (s0),
        .b     (carry_in),
        .sum   (sum),
        .carry (c1)
    );

    or g_cout (carry_out, c0, c1);

endmodule

// File: rtl/half_adder_structural.sv
// Gate-level half adder.
module half_adder_structural (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    xor g_sum   (sum, a, b);
    and g_carry (carry, a, b);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB first, one bit per clock,
// with valid/ready request and response handshakes.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int unsigned     CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  sum_sh_q;
    logic [WIDTH-1:0]  sum_sh_d;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;
    logic              fa_sum;
    logic              fa_cout;

    full_adder_structural u_fa (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    always_comb begin
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_sh_q   <= req_a;
                        b_sh_q   <= req_b;
                        carry_q  <= req_cin;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_cout;
                    // Counter holds on the last bit so it never exceeds WIDTH-1.
                    if (cnt_q == CntLast) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    // Result is masked outside DONE so no partial sum is ever visible.
    assign rsp_sum   = (state_q == ST_DONE) ? sum_sh_q : '0;
    assign rsp_cout  = (state_q == ST_DONE) ? carry_q : 1'b0;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller. It time-shares one full_adder_structural cell to add two WIDTH-bit operands, one bit per clock, LSB first. A registered carry feeds the cell's carry output back into its carry_in. Requests and responses use valid/ready handshakes, so the block sits between a requesting unit and a result consumer as a low-area alternative to a ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request operands valid.
req_ready  output  1  controller can accept a request.
req_a  input  WIDTH  operand A.
req_b  input  WIDTH  operand B.
req_cin  input  1  initial carry-in.
rsp_valid  output  1  result valid.
rsp_ready  input  1  consumer accepts result.
rsp_sum  output  WIDTH  sum result.
rsp_cout  output  1  final carry-out.
busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n=0, asynchronous): state=IDLE; shift registers, carry register and bit counter = 0; rsp_valid=0, rsp_sum=0, rsp_cout=0, busy=0, req_ready=1.
- Output decode: req_ready = (state==IDLE); rsp_valid = (state==DONE); busy = (state!=IDLE). All are decoded from the state register only, with no combinational path from req_valid or rsp_ready.
- Accept: on an edge where req_valid & req_ready:
  - a_sh<=req_a, b_sh<=req_b, carry_q<=req_cin, sum_sh<=0, cnt<=0;
  - state->RUN.
- RUN, per cycle:
  - cell inputs are a_sh[0], b_sh[0], carry_q;
  - a_sh and b_sh shift right by 1, zero fill;
  - sum_sh shifts right with the cell's sum bit entering the MSB;
  - carry_q<=carry_out; cnt<=cnt+1.
  - When cnt==WIDTH-1, state->DONE on the same edge.
- Counter width is max(1, clog2(WIDTH)). No wrap: cnt never exceeds WIDTH-1.
- DONE: rsp_sum=sum_sh and rsp_cout=carry_q. Both hold stable while rsp_valid=1 && rsp_ready=0. On rsp_ready=1, state->IDLE.
- Latency: request accepted at edge k gives rsp_valid=1 from edge k+WIDTH. Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, response handshake).
- req_valid while busy: ignored, nothing latched. The requester holds its operands until req_ready=1.
- rsp_ready while not DONE: ignored.
- WIDTH=1: a single RUN cycle, then DONE.
- Reset mid-RUN or mid-DONE: immediate abort to the reset values above. No partial result is ever presented.
- Arithmetic: {rsp_cout, rsp_sum} == req_a + req_b + req_cin, exact over WIDTH+1 bits.

Decomposition:
- Shared package serial_add_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
  - counter-width helper function cnt_w(WIDTH).
- Sub-module: one instance of the existing full_adder_structural (which depends on half_adder_structural) as the datapath slice.
- FSM, counter, shift registers and carry flop stay in serial_add_ctrl.

Test Plan:
1. WIDTH=8; a=0x5A, b=0x3C, cin=0, rsp_ready=1 -> rsp_valid 8 cycles after accept; rsp_sum=0x96, rsp_cout=0.
2. a=0xFF, b=0x01, cin=0 -> rsp_sum=0x00, rsp_cout=1. Then a=0xFF, b=0xFF, cin=1 -> rsp_sum=0xFF, rsp_cout=1.
3. Backpressure: a=0x12, b=0x34, rsp_ready=0 for 5 cycles after rsp_valid -> rsp_sum=0x46 held stable, req_ready=0, busy=1. Release -> IDLE next edge, req_ready=1.
4. Busy rejection: second req_valid with a=0x01, b=0x01 asserted during RUN -> not accepted; the first result is unaffected. Held request is accepted one cycle after the response handshake -> 0x02.
5. Reset abort: rst_n=0 pulse at RUN cycle 3 of a=0xAA, b=0x55 -> all outputs zero asynchronously, req_ready=1. Next request a=0x0F, b=0xF0, cin=1 -> rsp_sum=0x00, rsp_cout=1.
6. WIDTH=1 build: a=1, b=1, cin=1 -> rsp_valid 1 cycle after accept; rsp_sum=1, rsp_cout=1.
